floor_gray_encoder: RTL

Sequential binary-to-Gray position encoder for the elevator controller. It accepts a binary target floor over a valid/ready handshake and walks the car position one floor per step period toward that target. Each step updates a registered 3-bit Gray-coded position, so exactly one output bit changes per step. It sits between the floor-request logic and any consumer of Gray-coded car position, such as the Gray-to-binary decode path and the display path.

---
 rtl/floor_pkg.sv | 20 ++
 rtl/floor_gray_encoder_if.sv | 25 ++
 rtl/floor_gray_encoder.sv | 118 +++++++++++
 3 files changed

// File: rtl/floor_pkg.sv
// Shared definitions for the Gray-coded car position path.
// Used by the encoder and by the Gray-to-binary decode side.
//   FLOOR_W  : width of a floor number (binary and Gray)
//   state_e  : encoder FSM states
//   bin2gray : binary -> reflected Gray conversion
package floor_pkg;

    localparam int FLOOR_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE   = 2'd1,
        ARRIVE = 2'd2
    } state_e;

    function automatic logic [FLOOR_W-1:0] bin2gray(input logic [FLOOR_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/floor_gray_encoder_if.sv
// Target-floor request handshake between the floor-request logic (master)
// and the Gray position encoder (slave).
//   req_valid : request present, held until accepted
//   req_floor : binary target floor
//   req_ready : slave can accept a request this cycle
interface floor_gray_encoder_if;
    import floor_pkg::*;

    logic               req_valid;
    logic [FLOOR_W-1:0] req_floor;
    logic               req_ready;

    modport master (
        output req_valid,
        output req_floor,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_floor,
        output req_ready
    );

endinterface

// File: rtl/floor_gray_encoder.sv
// Sequential binary-to-Gray car position encoder.
// Accepts a binary target floor and walks the car one floor every
// STEP_CYCLES clocks toward it, publishing the position in Gray code so
// that exactly one output bit changes per step.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   req_if    : request handshake (valid / floor / ready)
//   gray_out  : registered Gray-coded car position
//   moving    : high while stepping toward the target
//   dir_up    : direction of the current or last move (1 = up)
//   arrived   : one-cycle pulse on reaching the target
//   req_err   : one-cycle pulse when a request above MAX_FLOOR is accepted
module floor_gray_encoder
    import floor_pkg::*;
#(
    parameter int STEP_CYCLES = 4,
    parameter int MAX_FLOOR   = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    floor_gray_encoder_if.slave req_if,
    output logic [FLOOR_W-1:0] gray_out,
    output logic               moving,
    output logic               dir_up,
    output logic               arrived,
    output logic               req_err
);

    localparam logic [7:0]         TMR_RELOAD = 8'(STEP_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] MAX_F      = FLOOR_W'(MAX_FLOOR);

    state_e             state_q, state_d;
    logic [FLOOR_W-1:0] pos_q,   pos_d;
    logic [FLOOR_W-1:0] tgt_q,   tgt_d;
    logic [7:0]         tmr_q,   tmr_d;
    logic [FLOOR_W-1:0] gray_q,  gray_d;
    logic               dir_q,   dir_d;
    logic               err_q,   err_d;
    logic [FLOOR_W-1:0] next_pos;

    // The target always lies on the side dir_q points to, so the step
    // never wraps and pos stays inside 0..MAX_FLOOR.
    assign next_pos = dir_q ? (pos_q + FLOOR_W'(1)) : (pos_q - FLOOR_W'(1));

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        tgt_d   = tgt_q;
        tmr_d   = tmr_q;
        gray_d  = gray_q;
        dir_d   = dir_q;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_if.req_valid) begin
                    if (req_if.req_floor > MAX_F) begin
                        err_d = 1'b1;
                    end else if (req_if.req_floor == pos_q) begin
                        state_d = ARRIVE;
                    end else begin
                        tgt_d   = req_if.req_floor;
                        dir_d   = (req_if.req_floor > pos_q);
                        tmr_d   = TMR_RELOAD;
                        state_d = MOVE;
                    end
                end
            end
            MOVE: begin
                if (tmr_q != 8'd0) begin
                    tmr_d = tmr_q - 8'd1;
                end else begin
                    pos_d  = next_pos;
                    gray_d = bin2gray(next_pos);
                    tmr_d  = TMR_RELOAD;
                    if (next_pos == tgt_q) begin
                        state_d = ARRIVE;
                    end
                end
            end
            ARRIVE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pos_q   <= '0;
            tgt_q   <= '0;
            tmr_q   <= '0;
            gray_q  <= '0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            tgt_q   <= tgt_d;
            tmr_q   <= tmr_d;
            gray_q  <= gray_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    // Status outputs are pure decodes of the registered state.
    assign req_if.req_ready = (state_q == IDLE);
    assign moving           = (state_q == MOVE);
    assign arrived          = (state_q == ARRIVE);
    assign gray_out         = gray_q;
    assign dir_up           = dir_q;
    assign req_err          = err_q;

endmodule
